// File: rtl/synth_pkg.sv
// Shared voice types and per-instrument sample-region tables for the playback address generator.
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSTAIN = 2'd1,
        RELEASE = 2'd2
    } voice_state_t;

    localparam int unsigned TBL_W     = 16;
    localparam int unsigned NUM_INSTR = 4;

    typedef logic [TBL_W-1:0] tbl_addr_t;

    // Region layout per instrument: attack starts at START, the sustain loop spans
    // LOOP_START..LOOP_END inclusive, and the release tail runs up to END.
    localparam tbl_addr_t INSTR_START      [NUM_INSTR] = '{16'h0000, 16'h0000, 16'h4000, 16'hC000};
    localparam tbl_addr_t INSTR_LOOP_START [NUM_INSTR] = '{16'h0000, 16'h0100, 16'h4000, 16'hC800};
    localparam tbl_addr_t INSTR_LOOP_END   [NUM_INSTR] = '{16'h00FF, 16'h01FF, 16'h7FFF, 16'hCFFF};
    localparam tbl_addr_t INSTR_END        [NUM_INSTR] = '{16'h00FF, 16'h03FF, 16'h7FFF, 16'hFFFF};

endpackage

// File: rtl/sample_phase_step.sv
// Combinational phase step: advances the accumulator by inc and resolves loop wrap or end-of-tail.
module sample_phase_step
    import synth_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned FRAC_W = 8
) (
    input  logic [ADDR_W+FRAC_W-1:0] phase_i,
    input  logic [ADDR_W-1:0]        inc_i,
    input  logic [ADDR_W-1:0]        loop_start_i,
    input  logic [ADDR_W-1:0]        loop_end_i,
    input  logic [ADDR_W-1:0]        end_i,
    input  voice_state_t             mode_i,
    output logic [ADDR_W+FRAC_W-1:0] phase_o,
    output logic [ADDR_W+FRAC_W-1:0] loop_phase_o,
    output logic                     wrap_o,
    output logic                     end_o
);

    localparam int unsigned PH_W = ADDR_W + FRAC_W;

    logic [PH_W:0]     sum;
    logic [PH_W:0]     span;
    logic [PH_W:0]     wrapped;
    logic [ADDR_W-1:0] loop_len;
    logic              beyond_loop;
    logic              beyond_end;

    always_comb begin
        sum      = {1'b0, phase_i} + {{(FRAC_W + 1){1'b0}}, inc_i};
        loop_len = loop_end_i - loop_start_i + ADDR_W'(1);
        span     = {1'b0, loop_len, {FRAC_W{1'b0}}};
        wrapped  = sum - span;

        // A carry out of the 24-bit accumulator is past every table bound.
        beyond_loop = sum[PH_W] | (sum[PH_W-1:FRAC_W] > loop_end_i);
        beyond_end  = sum[PH_W] | (sum[PH_W-1:FRAC_W] > end_i);

        phase_o = sum[PH_W-1:0];

        if (wrapped[PH_W] || (wrapped[PH_W-1:FRAC_W] > loop_end_i)) begin
            loop_phase_o = {loop_start_i, {FRAC_W{1'b0}}};
        end else begin
            loop_phase_o = wrapped[PH_W-1:0];
        end

        wrap_o = (mode_i == SUSTAIN) && beyond_loop;
        end_o  = (mode_i == RELEASE) && beyond_end;
    end

endmodule

// File: rtl/sample_addr_gen.sv
// Per-voice playback address generator: fixed-point phase accumulator with sustain looping and release tail.
module sample_addr_gen
    import synth_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned FRAC_W  = 8,
    parameter int unsigned N_INSTR = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       sample_tick,
    input  logic                       note_on,
    input  logic                       note_off,
    input  logic [$clog2(N_INSTR)-1:0] instr_in,
    input  logic [ADDR_W-1:0]          pitch_inc,
    output logic [ADDR_W-1:0]          Addr,
    output logic [$clog2(N_INSTR)-1:0] instr_sel,
    output logic                       playing,
    output logic                       done
);

    localparam int unsigned PH_W = ADDR_W + FRAC_W;
    localparam int unsigned IS_W = $clog2(N_INSTR);

    voice_state_t      state_q;
    logic [PH_W-1:0]   phase_q;
    logic [IS_W-1:0]   instr_q;
    logic [ADDR_W-1:0] inc_q;
    logic              playing_q;
    logic              done_q;

    logic [PH_W-1:0]   step_phase;
    logic [PH_W-1:0]   step_loop;
    logic              step_wrap;
    logic              step_end;

    sample_phase_step #(
        .ADDR_W (ADDR_W),
        .FRAC_W (FRAC_W)
    ) u_step (
        .phase_i      (phase_q),
        .inc_i        (inc_q),
        .loop_start_i (INSTR_LOOP_START[instr_q]),
        .loop_end_i   (INSTR_LOOP_END[instr_q]),
        .end_i        (INSTR_END[instr_q]),
        .mode_i       (state_q),
        .phase_o      (step_phase),
        .loop_phase_o (step_loop),
        .wrap_o       (step_wrap),
        .end_o        (step_end)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            instr_q   <= '0;
            inc_q     <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (note_on) begin
                // Load takes priority over a same-cycle tick or note_off.
                state_q   <= SUSTAIN;
                instr_q   <= instr_in;
                inc_q     <= pitch_inc;
                phase_q   <= {INSTR_START[instr_in], {FRAC_W{1'b0}}};
                playing_q <= 1'b1;
            end else begin
                unique case (state_q)
                    SUSTAIN: begin
                        if (sample_tick) begin
                            phase_q <= step_wrap ? step_loop : step_phase;
                        end
                        if (note_off) begin
                            state_q <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (sample_tick) begin
                            if (step_end) begin
                                state_q   <= IDLE;
                                playing_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                phase_q <= step_phase;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Addr      = phase_q[PH_W-1:FRAC_W];
    assign instr_sel = instr_q;
    assign playing   = playing_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sample_addr_gen.sv
// Directed and randomized checks of sample_addr_gen against an arithmetic voice model.
module tb_sample_addr_gen;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic        note_on = 1'b0;
    logic        note_off = 1'b0;
    logic [1:0]  instr_in = 2'd0;
    logic [15:0] pitch_inc = 16'd0;
    logic [15:0] Addr;
    logic [1:0]  instr_sel;
    logic        playing;
    logic        done;

    int total = 0;
    int bad   = 0;

    int T_START [4] = '{'h0000, 'h0000, 'h4000, 'hC000};
    int T_LS    [4] = '{'h0000, 'h0100, 'h4000, 'hC800};
    int T_LE    [4] = '{'h00FF, 'h01FF, 'h7FFF, 'hCFFF};
    int T_END   [4] = '{'h00FF, 'h03FF, 'h7FFF, 'hFFFF};

    // Model: phase as a plain integer in 1/256 address units.
    int m_phase = 0;
    int m_instr = 0;
    int m_inc   = 0;
    bit m_active = 1'b0;
    bit m_held   = 1'b0;
    bit m_done   = 1'b0;

    always #5 Clk = ~Clk;

    sample_addr_gen #(
        .ADDR_W  (16),
        .FRAC_W  (8),
        .N_INSTR (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .sample_tick (sample_tick),
        .note_on     (note_on),
        .note_off    (note_off),
        .instr_in    (instr_in),
        .pitch_inc   (pitch_inc),
        .Addr        (Addr),
        .instr_sel   (instr_sel),
        .playing     (playing),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic model_clock(input bit rst, input bit on, input bit off, input bit tick,
                               input int ins, input int inc);
        int n;
        m_done = 1'b0;
        if (rst) begin
            m_phase = 0; m_instr = 0; m_inc = 0; m_active = 1'b0; m_held = 1'b0;
        end else if (on) begin
            m_instr = ins; m_inc = inc; m_phase = T_START[ins] * 256;
            m_active = 1'b1; m_held = 1'b1;
        end else if (m_active) begin
            if (tick) begin
                n = m_phase + m_inc;
                if (m_held) begin
                    if (n / 256 > T_LE[m_instr]) begin
                        n = n - (T_LE[m_instr] - T_LS[m_instr] + 1) * 256;
                        if (n / 256 > T_LE[m_instr]) n = T_LS[m_instr] * 256;
                    end
                    m_phase = n;
                end else if (n / 256 > T_END[m_instr]) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_phase = n;
                end
            end
            if (off) m_held = 1'b0;
        end
    endtask

    task automatic cyc(input bit rst, input bit on, input bit off, input bit tick,
                       input logic [1:0] ins, input logic [15:0] inc);
        Reset = rst; note_on = on; note_off = off; sample_tick = tick;
        instr_in = ins; pitch_inc = inc;
        @(posedge Clk);
        #1;
        model_clock(rst, on, off, tick, int'(ins), int'(inc));
        Reset = 1'b0; note_on = 1'b0; note_off = 1'b0; sample_tick = 1'b0;
        check("addr",      {16'd0, Addr},      32'(m_phase / 256));
        check("instr_sel", {30'd0, instr_sel}, 32'(m_instr));
        check("playing",   {31'd0, playing},   {31'd0, m_active});
        check("done",      {31'd0, done},      {31'd0, m_done});
    endtask

    task automatic tick_until(input int target_phase, input int budget, input string tag);
        int k;
        for (k = 0; k < budget && m_phase != target_phase; k++) cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check(tag, 32'(m_phase), 32'(target_phase));
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 2'd0, 16'd0);
        cyc(1, 1, 1, 1, 2'd3, 16'h0100);
        check("rst_addr", {16'd0, Addr}, 32'h0);
        check("rst_play", {31'd0, playing}, 32'h0);

        // Reset mid-RELEASE
        cyc(0, 1, 0, 0, 2'd1, 16'h0100);
        repeat (5) cyc(0, 0, 0, 1, 2'd0, 16'd0);
        cyc(0, 0, 1, 0, 2'd0, 16'd0);
        repeat (3) cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("rel_play", {31'd0, playing}, 32'h1);
        cyc(1, 0, 0, 1, 2'd0, 16'd0);
        check("t1_addr", {16'd0, Addr}, 32'h0);
        check("t1_play", {31'd0, playing}, 32'h0);
        check("t1_done", {31'd0, done}, 32'h0);
        check("t1_isel", {30'd0, instr_sel}, 32'h0);
        repeat (4) cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t1_idle_addr", {16'd0, Addr}, 32'h0);

        // Native pitch through the instr 1 loop
        cyc(0, 1, 0, 0, 2'd1, 16'h0100);
        check("t2_start", {16'd0, Addr}, 32'h0);
        repeat (16'h1FF) cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t2_top", {16'd0, Addr}, 32'h01FF);
        cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t2_wrap", {16'd0, Addr}, 32'h0100);
        check("t2_play", {31'd0, playing}, 32'h1);

        // Release at 0x150, run the tail out to END
        tick_until(32'h15000, 200, "t3_reach150");
        cyc(0, 0, 1, 0, 2'd0, 16'd0);
        tick_until(32'h3FF00, 1000, "t3_reach3ff");
        check("t3_tail_addr", {16'd0, Addr}, 32'h03FF);
        check("t3_tail_play", {31'd0, playing}, 32'h1);
        cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t3_done", {31'd0, done}, 32'h1);
        check("t3_play", {31'd0, playing}, 32'h0);
        check("t3_hold", {16'd0, Addr}, 32'h03FF);
        cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t3_done_pulse", {31'd0, done}, 32'h0);
        check("t3_hold2", {16'd0, Addr}, 32'h03FF);

        // Fractional wrap preserving the fraction
        cyc(0, 1, 0, 0, 2'd1, 16'h0180);
        repeat (341) cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t4_pre", {16'd0, Addr}, 32'h01FF);
        cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t4_wrap", {16'd0, Addr}, 32'h0101);
        cyc(0, 1, 0, 0, 2'd0, 16'h0300);
        tick_until(32'h0FE00, 400, "t4b_reachfe");
        cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t4b_wrap", {16'd0, Addr}, 32'h0001);

        // Same-cycle note_on/note_off, then retrigger
        cyc(0, 1, 1, 1, 2'd2, 16'h0200);
        check("t5_addr", {16'd0, Addr}, 32'h4000);
        check("t5_play", {31'd0, playing}, 32'h1);
        repeat (3) cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t5_sustain", {16'd0, Addr}, 32'h4006);
        cyc(0, 1, 0, 1, 2'd3, 16'h0050);
        check("t5_retrig_isel", {30'd0, instr_sel}, 32'h3);
        check("t5_retrig_addr", {16'd0, Addr}, 32'hC000);

        // 25-bit carry at the top of instr 3's tail
        cyc(0, 1, 0, 0, 2'd3, 16'h0400);
        tick_until(32'hCFFC00, 1200, "t6_reachcffc");
        cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t6_loopwrap", {16'd0, Addr}, 32'hC800);
        cyc(0, 0, 1, 0, 2'd0, 16'd0);
        tick_until(32'hFFFC00, 4000, "t6_reachfffc");
        cyc(0, 0, 0, 1, 2'd0, 16'd0);
        check("t6_done", {31'd0, done}, 32'h1);
        check("t6_nowrap", {16'd0, Addr}, 32'hFFFC);
        check("t6_play", {31'd0, playing}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit r_rst, r_on, r_off, r_tick;
            logic [15:0] r_inc;
            r_rst  = ($urandom_range(0, 499) == 0);
            r_on   = ($urandom_range(0, 63) == 0);
            r_off  = ($urandom_range(0, 31) == 0);
            r_tick = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 7))
                0:       r_inc = 16'h0000;
                1:       r_inc = 16'($urandom_range(16'hF000, 16'hFFFF));
                default: r_inc = 16'($urandom_range(0, 16'h0900));
            endcase
            cyc(r_rst, r_on, r_off, r_tick, 2'($urandom_range(0, 3)), r_inc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
